// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's instruction-memory, redirect and decode-side
// signals. The master modport is the fetch stage; the slave modport is the
// environment (memory, branch unit and decoder) facing it.
interface if_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [5:0]  instr_op_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] fetch_cnt_o;

  modport master (
    output imem_req_o, imem_addr_o, valid_o, instr_o, instr_op_o,
           pc_o, pc_plus4_o, fetch_cnt_o,
    input  imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, instr_o, instr_op_o,
           pc_o, pc_plus4_o, fetch_cnt_o,
    output imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, ready_i
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one word-aligned request at a time, holds the
// returned word for decode until it is accepted, and follows branch redirects.
// A redirect that arrives while a request is still outstanding leaves the
// request up at its old address (DISCARD) until the memory answers, then drops
// that answer and restarts at the redirect target.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk_i,
  input  logic     rst_i,
  if_stage_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_q;        // next fetch address
  logic [31:0] addr_reg;    // address of the request currently on the bus
  logic        req_reg;
  logic        valid_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_out_reg;
  logic [31:0] cnt_reg;
  logic [31:0] redirect_target;

  // Branch targets are forced onto a word boundary.
  assign redirect_target = {bus.redirect_pc_i[31:2], 2'b00};

  assign bus.imem_req_o  = req_reg;
  assign bus.imem_addr_o = addr_reg;
  assign bus.valid_o     = valid_reg;
  assign bus.instr_o     = instr_reg;
  assign bus.instr_op_o  = instr_reg[31:26];
  assign bus.pc_o        = pc_out_reg;
  assign bus.pc_plus4_o  = pc_out_reg + 32'd4;
  assign bus.fetch_cnt_o = cnt_reg;

  // Fetch FSM with registered request/delivery outputs; redirect wins over
  // every other event in every state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg  <= IDLE;
      pc_q       <= RESET_PC;
      addr_reg   <= RESET_PC;
      req_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      instr_reg  <= 32'd0;
      pc_out_reg <= RESET_PC;
      cnt_reg    <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= FETCH;
          req_reg   <= 1'b1;
          if (bus.redirect_i) begin
            pc_q     <= redirect_target;
            addr_reg <= redirect_target;
          end else begin
            addr_reg <= pc_q;
          end
        end

        FETCH: begin
          if (bus.redirect_i) begin
            pc_q      <= redirect_target;
            valid_reg <= 1'b0;
            if (bus.imem_ack_i) begin
              // Answer for the stale address arrives now: drop it and
              // immediately request the target.
              addr_reg  <= redirect_target;
              state_reg <= FETCH;
            end else begin
              // Request must stay up at its old address until answered.
              state_reg <= DISCARD;
            end
          end else if (bus.imem_ack_i) begin
            instr_reg  <= bus.imem_data_i;
            pc_out_reg <= pc_q;
            pc_q       <= pc_q + 32'd4;
            valid_reg  <= 1'b1;
            req_reg    <= 1'b0;
            state_reg  <= HOLD;
          end
        end

        HOLD: begin
          if (bus.ready_i) begin
            cnt_reg <= cnt_reg + 32'd1;
          end
          if (bus.redirect_i) begin
            pc_q      <= redirect_target;
            addr_reg  <= redirect_target;
            valid_reg <= 1'b0;
            req_reg   <= 1'b1;
            state_reg <= FETCH;
          end else if (bus.ready_i) begin
            addr_reg  <= pc_q;
            valid_reg <= 1'b0;
            req_reg   <= 1'b1;
            state_reg <= FETCH;
          end
        end

        DISCARD: begin
          if (bus.redirect_i) begin
            pc_q <= redirect_target;
            if (bus.imem_ack_i) begin
              addr_reg  <= redirect_target;
              state_reg <= FETCH;
            end
          end else if (bus.imem_ack_i) begin
            addr_reg  <= pc_q;
            state_reg <= FETCH;
          end
        end

        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
